pc_address_unit: RTL and testbench
==================================

# pc_address_unit

Program-counter and address-bus generator for the 6502 core. Sits directly upstream of `instruction_decode`: it owns the 16-bit PC and drives the external address bus from the decoder's `pc_enable` / `address_select` / `memory_address` controls. Out of reset it fetches the reset vector; while doing so it holds the decoder in reset.

## Interface
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `VECTOR_ADDR`, 16'hFFFC: address of the reset-vector low byte; the high byte is at `VECTOR_ADDR+1`.

- `clk`  in  1: core clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `clk_enable`  in  1: qualifies every state update.
- `pc_enable`  in  2: 00 hold, 01 load `memory_address`, 10 branch (PC + sign-extended `branch_offset`), 11 increment.
- `address_select`  in  2: 0 PC, 1 `memory_address`, 2 {8'h00, `alu_result`}, 3 {8'h01, `stack_pointer`}.
- `memory_address`  in  16: decoder-supplied absolute address.
- `alu_result`  in  8: ALU output, used as a zero-page address.
- `stack_pointer`  in  8: SP value.
- `branch_offset`  in  8: signed branch displacement.
- `data_in`  in  8: memory read data, valid in the same cycle its address is presented.
- `address_bus`  out  16: external address, combinational.
- `pc`  out  16: current PC, registered.
- `vector_busy`  out  1: high while the vector fetch runs; the core ORs it into the decoder reset.
- `page_cross`  out  1: branch target high byte differs from `pc[15:8]`.

## Operation
- **FSM states:** V_LOW, V_HIGH, RUN. Every transition and PC update occurs only on a rising `clk` edge with `clk_enable`=1. With `clk_enable`=0, all state holds.
- **V_LOW:**
  - `address_bus`=`VECTOR_ADDR`, `vector_busy`=1.
  - On edge: `pc[7:0]`<=`data_in`, go to V_HIGH.
- **V_HIGH:**
  - `address_bus`=`VECTOR_ADDR+1`, `vector_busy`=1.
  - On edge: `pc[15:8]`<=`data_in`, go to RUN.
- **RUN:**
  - `vector_busy`=0. `address_bus` is selected by `address_select`.
  - On edge, PC updates per `pc_enable`.
- During V_LOW and V_HIGH, `pc_enable` and `address_select` are ignored.
- **Arithmetic:** all 16-bit, modulo 2^16.
  - Increment: FFFF -> 0000.
  - Branch: PC + {{8{off[7]}}, off}.
  - No carry or flag output beyond `page_cross`.
- **`page_cross`:** combinational. Equals (target[15:8] != `pc[15:8]`) only when in RUN and `pc_enable`=10; 0 otherwise.
- **Address timing:** `address_bus` always reflects the pre-update PC of the current cycle. The PC update becomes visible the cycle after the edge.

## Timing
- **Reset (async, immediate):**
  - State=V_LOW, `pc`=`RESET_PC`, `vector_busy`=1, `page_cross`=0, `address_bus`=`VECTOR_ADDR`.
- **Vector-fetch latency:** exactly 2 enabled cycles from reset release to RUN. The first decoder-visible fetch is from the loaded vector on the third enabled cycle.
- **Reset mid-fetch or mid-run:** immediately returns to V_LOW with `pc`=`RESET_PC`. No partial vector byte is retained.
- **Load/branch/increment:** single cycle. The new PC drives `address_bus` (sel 0) on the next cycle.
- **Illegal input:** none; every `pc_enable` and `address_select` encoding is defined.

## Configuration
- **`RESET_VECTOR_FETCH_EN` defined:** behaviour as above.
- **`RESET_VECTOR_FETCH_EN` undefined:**
  - The FSM is removed. Reset state is RUN and `vector_busy` is tied 0.
  - Reset `address_bus`=`RESET_PC` (with `address_select`=0).
  - The decoder starts fetching at `RESET_PC` on the first enabled cycle.

## Test plan
- **Vector fetch (EN defined):** release reset; `data_in`=34 at `address_bus`=FFFC, then 12 at FFFD.
  - `vector_busy` is 1,1,0; `pc`=1234 after 2 enabled edges.
  - `address_bus`=1234 with sel 0.
- **Increment wrap:** `pc`=FFFF, `pc_enable`=11 -> `pc`=0000 next cycle.
- **Branch:**
  - `pc`=1210, offset 80, `pc_enable`=10 -> `page_cross`=1, `pc`=1190.
  - `pc`=12F0, offset 05 -> `page_cross`=0, `pc`=12F5.
- **Mux:** `memory_address`=ABCD, `alu_result`=42, `stack_pointer`=FD.
  - sel 1/2/3 -> `address_bus` ABCD / 0042 / 01FD.
  - `pc` unchanged with `pc_enable`=00.
- **Hold and load:**
  - `clk_enable`=0 for 3 cycles with `pc_enable`=11 -> `pc` and state frozen.
  - `pc_enable`=01 with `memory_address`=C000 -> `pc`=C000.
- **Async reset:** assert `rst_n` low between edges during V_HIGH -> immediately `pc`=`RESET_PC`, `address_bus`=FFFC.
  - The fetch restarts from V_LOW.
  - With EN undefined: `pc`=`RESET_PC`, `vector_busy`=0.

Source files
------------

// File: rtl/pc_address_unit.sv
// Program counter and address-bus generator for the 6502 core.
// Define RESET_VECTOR_FETCH_EN to fetch the PC from the reset vector before running.
module pc_address_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] VECTOR_ADDR = 16'hFFFC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_enable,
    input  logic [1:0]  pc_enable,
    input  logic [1:0]  address_select,
    input  logic [15:0] memory_address,
    input  logic [7:0]  alu_result,
    input  logic [7:0]  stack_pointer,
    input  logic [7:0]  branch_offset,
    input  logic [7:0]  data_in,
    output logic [15:0] address_bus,
    output logic [15:0] pc,
    output logic        vector_busy,
    output logic        page_cross
);

    localparam logic [1:0] PC_HOLD   = 2'b00;
    localparam logic [1:0] PC_LOAD   = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b10;
    localparam logic [1:0] PC_INC    = 2'b11;

    logic [15:0] pc_reg;
    logic [15:0] pc_next;
    logic [15:0] branch_target;
    logic [15:0] run_address;
    logic [15:0] run_pc_next;
    logic        in_run;

    assign pc            = pc_reg;
    assign branch_target = pc_reg + {{8{branch_offset[7]}}, branch_offset};

    always_comb begin
        run_address = pc_reg;
        case (address_select)
            2'd0:    run_address = pc_reg;
            2'd1:    run_address = memory_address;
            2'd2:    run_address = {8'h00, alu_result};
            default: run_address = {8'h01, stack_pointer};
        endcase
    end

    always_comb begin
        run_pc_next = pc_reg;
        case (pc_enable)
            PC_HOLD:   run_pc_next = pc_reg;
            PC_LOAD:   run_pc_next = memory_address;
            PC_BRANCH: run_pc_next = branch_target;
            default:   run_pc_next = pc_reg + 16'd1;
        endcase
    end

    assign page_cross = in_run && (pc_enable == PC_BRANCH) &&
                        (branch_target[15:8] != pc_reg[15:8]);

`ifdef RESET_VECTOR_FETCH_EN

    typedef enum logic [1:0] {
        V_LOW  = 2'd0,
        V_HIGH = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= V_LOW;
        end else if (clk_enable) begin
            state <= state_next;
        end
    end

    // Vector bytes are patched into the PC one half at a time while the decoder is held off.
    always_comb begin
        state_next  = state;
        pc_next     = pc_reg;
        address_bus = run_address;
        vector_busy = 1'b0;
        in_run      = 1'b0;
        case (state)
            V_LOW: begin
                address_bus = VECTOR_ADDR;
                vector_busy = 1'b1;
                pc_next     = {pc_reg[15:8], data_in};
                state_next  = V_HIGH;
            end
            V_HIGH: begin
                address_bus = VECTOR_ADDR + 16'd1;
                vector_busy = 1'b1;
                pc_next     = {data_in, pc_reg[7:0]};
                state_next  = RUN;
            end
            RUN: begin
                in_run     = 1'b1;
                pc_next    = run_pc_next;
                state_next = RUN;
            end
            default: begin
                address_bus = VECTOR_ADDR;
                vector_busy = 1'b1;
                state_next  = V_LOW;
            end
        endcase
    end

`else

    logic unused_inputs;

    // Without the vector fetch, data_in and the vector address have no consumer.
    assign unused_inputs = ^{data_in, VECTOR_ADDR};

    assign in_run      = 1'b1;
    assign vector_busy = 1'b0;
    assign address_bus = run_address;
    assign pc_next     = run_pc_next;

`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= RESET_PC;
        end else if (clk_enable) begin
            pc_reg <= pc_next;
        end
    end

endmodule

// File: tb/tb_pc_address_unit.sv
// Directed self-checking bench for pc_address_unit; follows RESET_VECTOR_FETCH_EN when defined.
module tb_pc_address_unit;

    logic        clk;
    logic        rst_n;
    logic        clk_enable;
    logic [1:0]  pc_enable;
    logic [1:0]  address_select;
    logic [15:0] memory_address;
    logic [7:0]  alu_result;
    logic [7:0]  stack_pointer;
    logic [7:0]  branch_offset;
    logic [7:0]  data_in;
    logic [15:0] address_bus;
    logic [15:0] pc;
    logic        vector_busy;
    logic        page_cross;

    int total;
    int bad;

    pc_address_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clk_enable     (clk_enable),
        .pc_enable      (pc_enable),
        .address_select (address_select),
        .memory_address (memory_address),
        .alu_result     (alu_result),
        .stack_pointer  (stack_pointer),
        .branch_offset  (branch_offset),
        .data_in        (data_in),
        .address_bus    (address_bus),
        .pc             (pc),
        .vector_busy    (vector_busy),
        .page_cross     (page_cross)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [1:0] pe, input logic [1:0] sel,
                                 input logic [15:0] ma, input logic [7:0] off,
                                 input logic [7:0] din, input logic ce);
        pc_enable      = pe;
        address_select = sel;
        memory_address = ma;
        branch_offset  = off;
        data_in        = din;
        clk_enable     = ce;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Load an arbitrary PC through the decoder path so later steps start from a known value.
    task automatic loadPc(input logic [15:0] value);
        applyStimulus(2'b01, 2'd0, value, 8'h00, 8'h00, 1'b1);
        tick();
        checkOutput("load_pc", pc, value);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        alu_result    = 8'h00;
        stack_pointer = 8'h00;
        applyStimulus(2'b00, 2'd0, 16'h0000, 8'h00, 8'h00, 1'b1);
        #2;
        $display("[TB] checking reset state");
        checkOutput("reset_pc", pc, 16'h0000);
        checkOutput("reset_page_cross", {15'd0, page_cross}, 16'h0000);
`ifdef RESET_VECTOR_FETCH_EN
        checkOutput("reset_addr", address_bus, 16'hFFFC);
        checkOutput("reset_busy", {15'd0, vector_busy}, 16'h0001);
        tick();
        rst_n = 1'b1;
        applyStimulus(2'b11, 2'd1, 16'hAAAA, 8'h00, 8'h34, 1'b1);
        checkOutput("vlow_addr", address_bus, 16'hFFFC);
        checkOutput("vlow_busy", {15'd0, vector_busy}, 16'h0001);
        tick();
        applyStimulus(2'b10, 2'd2, 16'hAAAA, 8'h80, 8'h12, 1'b1);
        checkOutput("vhigh_pc", pc, 16'h0034);
        checkOutput("vhigh_addr", address_bus, 16'hFFFD);
        checkOutput("vhigh_busy", {15'd0, vector_busy}, 16'h0001);
        checkOutput("vhigh_page_cross", {15'd0, page_cross}, 16'h0000);
        tick();
        applyStimulus(2'b00, 2'd0, 16'h0000, 8'h00, 8'h00, 1'b1);
        checkOutput("run_pc", pc, 16'h1234);
        checkOutput("run_busy", {15'd0, vector_busy}, 16'h0000);
        checkOutput("run_addr", address_bus, 16'h1234);
`else
        checkOutput("reset_addr", address_bus, 16'h0000);
        checkOutput("reset_busy", {15'd0, vector_busy}, 16'h0000);
        tick();
        rst_n = 1'b1;
        loadPc(16'h1234);
        checkOutput("run_busy", {15'd0, vector_busy}, 16'h0000);
`endif

        $display("[TB] address mux");
        alu_result    = 8'h42;
        stack_pointer = 8'hFD;
        applyStimulus(2'b00, 2'd1, 16'hABCD, 8'h00, 8'h00, 1'b1);
        checkOutput("mux_sel1", address_bus, 16'hABCD);
        applyStimulus(2'b00, 2'd2, 16'hABCD, 8'h00, 8'h00, 1'b1);
        checkOutput("mux_sel2", address_bus, 16'h0042);
        applyStimulus(2'b00, 2'd3, 16'hABCD, 8'h00, 8'h00, 1'b1);
        checkOutput("mux_sel3", address_bus, 16'h01FD);
        tick();
        checkOutput("mux_pc_hold", pc, 16'h1234);

        $display("[TB] branches");
        loadPc(16'h1210);
        applyStimulus(2'b10, 2'd0, 16'h0000, 8'h80, 8'h00, 1'b1);
        checkOutput("br_back_cross", {15'd0, page_cross}, 16'h0001);
        checkOutput("br_back_addr", address_bus, 16'h1210);
        tick();
        checkOutput("br_back_pc", pc, 16'h1190);
        applyStimulus(2'b00, 2'd0, 16'h0000, 8'h80, 8'h00, 1'b1);
        checkOutput("br_hold_no_cross", {15'd0, page_cross}, 16'h0000);
        loadPc(16'h12F0);
        applyStimulus(2'b10, 2'd0, 16'h0000, 8'h05, 8'h00, 1'b1);
        checkOutput("br_fwd_cross", {15'd0, page_cross}, 16'h0000);
        tick();
        checkOutput("br_fwd_pc", pc, 16'h12F5);
        applyStimulus(2'b10, 2'd0, 16'h0000, 8'h10, 8'h00, 1'b1);
        checkOutput("br_fwd_page_cross", {15'd0, page_cross}, 16'h0001);
        tick();
        checkOutput("br_fwd_page_pc", pc, 16'h1305);

        $display("[TB] increment wrap and clock enable hold");
        loadPc(16'hFFFF);
        applyStimulus(2'b11, 2'd0, 16'h0000, 8'h00, 8'h00, 1'b1);
        checkOutput("inc_addr", address_bus, 16'hFFFF);
        tick();
        checkOutput("inc_wrap", pc, 16'h0000);
        applyStimulus(2'b11, 2'd0, 16'h0000, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("ce_hold_pc", pc, 16'h0000);
        end
        applyStimulus(2'b11, 2'd0, 16'h0000, 8'h00, 8'h00, 1'b1);
        tick();
        checkOutput("ce_resume_pc", pc, 16'h0001);
        loadPc(16'hC000);
        applyStimulus(2'b00, 2'd0, 16'h0000, 8'h00, 8'h00, 1'b1);
        checkOutput("load_addr", address_bus, 16'hC000);

        $display("[TB] async reset");
        rst_n = 1'b0;
        #1;
        checkOutput("run_rst_pc", pc, 16'h0000);
`ifdef RESET_VECTOR_FETCH_EN
        checkOutput("run_rst_addr", address_bus, 16'hFFFC);
        checkOutput("run_rst_busy", {15'd0, vector_busy}, 16'h0001);
        tick();
        rst_n = 1'b1;
        applyStimulus(2'b00, 2'd0, 16'h0000, 8'h00, 8'h56, 1'b1);
        tick();
        checkOutput("refetch_vhigh_pc", pc, 16'h0056);
        checkOutput("refetch_vhigh_addr", address_bus, 16'hFFFD);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_pc", pc, 16'h0000);
        checkOutput("mid_rst_addr", address_bus, 16'hFFFC);
        checkOutput("mid_rst_busy", {15'd0, vector_busy}, 16'h0001);
        tick();
        rst_n = 1'b1;
        applyStimulus(2'b00, 2'd0, 16'h0000, 8'h00, 8'h78, 1'b0);
        tick();
        tick();
        checkOutput("vlow_ce_hold_addr", address_bus, 16'hFFFC);
        checkOutput("vlow_ce_hold_pc", pc, 16'h0000);
        applyStimulus(2'b00, 2'd0, 16'h0000, 8'h00, 8'h78, 1'b1);
        tick();
        checkOutput("restart_low_pc", pc, 16'h0078);
        applyStimulus(2'b00, 2'd0, 16'h0000, 8'h00, 8'h9A, 1'b1);
        tick();
        checkOutput("restart_pc", pc, 16'h9A78);
        checkOutput("restart_busy", {15'd0, vector_busy}, 16'h0000);
        checkOutput("restart_addr", address_bus, 16'h9A78);
`else
        checkOutput("run_rst_addr", address_bus, 16'h0000);
        checkOutput("run_rst_busy", {15'd0, vector_busy}, 16'h0000);
        tick();
        rst_n = 1'b1;
        applyStimulus(2'b11, 2'd0, 16'h0000, 8'h00, 8'h00, 1'b1);
        tick();
        checkOutput("restart_inc_pc", pc, 16'h0001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
